// File: rtl/alu_32.sv
// Registered 32-bit execute-stage ALU: add/sub/and/or/sll/sra plus not-equal,
// signed less-than and signed-overflow flags, all captured one cycle after the inputs.
module alu_32 (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [4:0]  ctrl_ALUopcode,
    input  logic [4:0]  ctrl_shiftamt,
    output logic [31:0] data_result,
    output logic        isNotEqual,
    output logic        isLessThan,
    output logic        overflow
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;

    logic        sub_sel;
    logic [31:0] addend_b;
    logic [31:0] sum;
    logic        sum_ovf;

    logic [31:0] diff;
    logic        diff_ovf;
    logic        diff_ne;
    logic        diff_lt;

    logic [31:0] sll_1, sll_2, sll_4, sll_8, sll_16;
    logic [31:0] sra_1, sra_2, sra_4, sra_8, sra_16;

    logic [31:0] next_result;
    logic        next_ovf;

    // Shared adder: subtraction is A + ~B + 1, so one overflow rule covers both ops.
    assign sub_sel  = (ctrl_ALUopcode == OP_SUB);
    assign addend_b = sub_sel ? ~data_operandB : data_operandB;
    assign sum      = data_operandA + addend_b + {31'd0, sub_sel};
    assign sum_ovf  = (data_operandA[31] == addend_b[31]) && (sum[31] != data_operandA[31]);

    // Flags come from a dedicated A - B so they are valid for every opcode.
    assign diff     = data_operandA + ~data_operandB + 32'd1;
    assign diff_ovf = (data_operandA[31] != data_operandB[31]) && (diff[31] != data_operandA[31]);
    assign diff_ne  = |diff;
    assign diff_lt  = diff[31] ^ diff_ovf;

    // Five-stage logical-left barrel shifter, zero fill.
    assign sll_1  = ctrl_shiftamt[0] ? {data_operandA[30:0], 1'b0}  : data_operandA;
    assign sll_2  = ctrl_shiftamt[1] ? {sll_1[29:0], 2'b0}          : sll_1;
    assign sll_4  = ctrl_shiftamt[2] ? {sll_2[27:0], 4'b0}          : sll_2;
    assign sll_8  = ctrl_shiftamt[3] ? {sll_4[23:0], 8'b0}          : sll_4;
    assign sll_16 = ctrl_shiftamt[4] ? {sll_8[15:0], 16'b0}         : sll_8;

    // Five-stage arithmetic-right barrel shifter, sign fill from A[31].
    assign sra_1  = ctrl_shiftamt[0] ? {{1{data_operandA[31]}}, data_operandA[31:1]} : data_operandA;
    assign sra_2  = ctrl_shiftamt[1] ? {{2{sra_1[31]}}, sra_1[31:2]}                 : sra_1;
    assign sra_4  = ctrl_shiftamt[2] ? {{4{sra_2[31]}}, sra_2[31:4]}                 : sra_2;
    assign sra_8  = ctrl_shiftamt[3] ? {{8{sra_4[31]}}, sra_4[31:8]}                 : sra_4;
    assign sra_16 = ctrl_shiftamt[4] ? {{16{sra_8[31]}}, sra_8[31:16]}               : sra_8;

    always_comb begin
        next_result = 32'd0;
        next_ovf    = 1'b0;
        case (ctrl_ALUopcode)
            OP_ADD: begin
                next_result = sum;
                next_ovf    = sum_ovf;
            end
            OP_SUB: begin
                next_result = sum;
                next_ovf    = sum_ovf;
            end
            OP_AND:  next_result = data_operandA & data_operandB;
            OP_OR:   next_result = data_operandA | data_operandB;
            OP_SLL:  next_result = sll_16;
            OP_SRA:  next_result = sra_16;
            default: begin
                next_result = 32'd0;
                next_ovf    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_result <= 32'd0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            data_result <= next_result;
            isNotEqual  <= diff_ne;
            isLessThan  <= diff_lt;
            overflow    <= next_ovf;
        end
    end

endmodule

// File: tb/tb_alu_32.sv
// Directed scoreboard bench for alu_32: a behavioural model pushes expectations
// when each operation is driven, and they are popped after the capturing edge.
module tb_alu_32;

    typedef struct packed {
        logic [31:0] result;
        logic        ne;
        logic        lt;
        logic        ovf;
    } exp_t;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;

    logic        clock;
    logic        reset_n;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  opcode;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        not_equal;
    logic        less_than;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    exp_t  exp_q[$];
    string tag_q[$];

    alu_32 dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .ctrl_ALUopcode (opcode),
        .ctrl_shiftamt  (shamt),
        .data_result    (result),
        .isNotEqual     (not_equal),
        .isLessThan     (less_than),
        .overflow       (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Overflow is judged by widening to 33 signed bits and checking the range.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] amt);
        exp_t               e;
        logic signed [32:0] wide;
        logic signed [31:0] sa;
        e.result = 32'd0;
        e.ovf    = 1'b0;
        e.ne     = (a != b);
        e.lt     = ($signed(a) < $signed(b));
        sa       = a;
        case (op)
            OP_ADD: begin
                e.result = a + b;
                wide     = $signed({a[31], a}) + $signed({b[31], b});
                e.ovf    = (wide[32] != wide[31]);
            end
            OP_SUB: begin
                e.result = a - b;
                wide     = $signed({a[31], a}) - $signed({b[31], b});
                e.ovf    = (wide[32] != wide[31]);
            end
            OP_AND:  e.result = a & b;
            OP_OR:   e.result = a | b;
            OP_SLL:  e.result = a << amt;
            OP_SRA:  e.result = sa >>> amt;
            default: e.result = 32'd0;
        endcase
        return e;
    endfunction

    task automatic compare_all(input string tag, input exp_t e);
        total++;
        assert (result === e.result) else begin
            bad++;
            $error("[TB] FAIL %s result: got %h expected %h", tag, result, e.result);
        end
        total++;
        assert (not_equal === e.ne) else begin
            bad++;
            $error("[TB] FAIL %s isNotEqual: got %b expected %b", tag, not_equal, e.ne);
        end
        total++;
        assert (less_than === e.lt) else begin
            bad++;
            $error("[TB] FAIL %s isLessThan: got %b expected %b", tag, less_than, e.lt);
        end
        total++;
        assert (ovf === e.ovf) else begin
            bad++;
            $error("[TB] FAIL %s overflow: got %b expected %b", tag, ovf, e.ovf);
        end
    endtask

    task automatic check_output();
        exp_t  e;
        string tag;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            compare_all(tag, e);
        end
    endtask

    task automatic apply_stimulus(input string tag, input logic [4:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] amt);
        @(negedge clock);
        opcode = op;
        op_a   = a;
        op_b   = b;
        shamt  = amt;
        exp_q.push_back(model(op, a, b, amt));
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        check_output();
    endtask

    initial begin
        exp_t        zero_exp;
        exp_t        rst_exp;
        logic [31:0] one;
        int          amts[10];

        zero_exp = '0;
        rst_exp  = '{result: 32'h8000_0000, ne: 1'b0, lt: 1'b0, ovf: 1'b1};
        one      = 32'd1;
        amts     = '{1, 2, 4, 8, 16, 3, 6, 12, 24, 0};

        reset_n = 1'b0;
        op_a    = 32'h1234_5678;
        op_b    = 32'h0000_0001;
        opcode  = OP_ADD;
        shamt   = 5'd0;
        #22;
        compare_all("reset_state", zero_exp);
        @(negedge clock);
        reset_n = 1'b1;

        apply_stimulus("or_ones_zero",  OP_OR,  32'hFFFF_FFFF, 32'h0000_0000, 5'd0);
        apply_stimulus("and_ones_zero", OP_AND, 32'hFFFF_FFFF, 32'h0000_0000, 5'd0);
        apply_stimulus("and_ones_ones", OP_AND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        apply_stimulus("and_mixed",     OP_AND, 32'hA5A5_F00F, 32'h3C3C_FF00, 5'd0);

        for (int i = 0; i < 31; i++)
            apply_stimulus($sformatf("add_walk_%0d", i), OP_ADD, one << i, one << i, 5'd0);
        apply_stimulus("add_neg_neg",     OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd0);
        apply_stimulus("add_pos_ovf",     OP_ADD, 32'h4000_0000, 32'h4000_0000, 5'd0);
        apply_stimulus("add_min_min_ovf", OP_ADD, 32'h8000_0000, 32'h8000_0000, 5'd0);

        for (int i = 0; i < 28; i++)
            apply_stimulus($sformatf("sub_walk_%0d", i), OP_SUB, 32'h11 << i, one << i, 5'd0);
        for (int i = 0; i < 32; i++)
            apply_stimulus($sformatf("sub_self_%0d", i), OP_SUB,
                           32'h8000_0001 << i, 32'h8000_0001 << i, 5'd0);
        apply_stimulus("sub_minus_one", OP_SUB, 32'h8000_0001, 32'h0000_0001, 5'd0);
        apply_stimulus("sub_min_min",   OP_SUB, 32'h8000_0000, 32'h8000_0000, 5'd0);
        apply_stimulus("sub_ovf",       OP_SUB, 32'h8000_0000, 32'h0F00_0000, 5'd0);

        apply_stimulus("cmp_pos_neg",   OP_SUB, 32'h0FFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        apply_stimulus("cmp_ovf_lt",    OP_SUB, 32'h8000_0001, 32'h7FFF_FFFF, 5'd0);
        apply_stimulus("cmp_zero_zero", OP_SUB, 32'h0000_0000, 32'h0000_0000, 5'd0);
        apply_stimulus("cmp_under_and", OP_AND, 32'hFFFF_FFFE, 32'h0000_0003, 5'd0);

        foreach (amts[k])
            apply_stimulus($sformatf("sll_%0d", amts[k]), OP_SLL, one, 32'hDEAD_BEEF, 5'(amts[k]));
        apply_stimulus("sll_pattern_7", OP_SLL, 32'hC000_00F3, 32'h0, 5'd7);
        apply_stimulus("sra_neg_4",     OP_SRA, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
        apply_stimulus("sra_pos_4",     OP_SRA, 32'h4000_0000, 32'h0, 5'd4);
        apply_stimulus("sra_zero",      OP_SRA, 32'h9234_5678, 32'h0, 5'd0);
        apply_stimulus("sra_neg_31",    OP_SRA, 32'h8765_4321, 32'h0, 5'd31);
        apply_stimulus("sra_mixed_13",  OP_SRA, 32'hB00F_1234, 32'h0, 5'd13);
        apply_stimulus("undef_op",      5'b10110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        apply_stimulus("undef_op_6",    5'b00110, 32'h4000_0000, 32'h4000_0000, 5'd0);

        // Reset asserted mid-cycle must clear outputs before the next edge.
        apply_stimulus("pre_reset_add", OP_ADD, 32'h4000_0000, 32'h4000_0000, 5'd0);
        #2;
        reset_n = 1'b0;
        #1;
        compare_all("async_reset", zero_exp);
        @(posedge clock);
        #1;
        compare_all("reset_held", zero_exp);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        compare_all("after_reset", rst_exp);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("[TB] FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
